// File: rtl/sprite_plotter.sv
// Sprite plotter: streams garbage (20x20) or press (40x60) sprites to a VGA pixel port, raster order.
// Optional one-entry pending-command slot enabled by defining SPRITE_PLOTTER_CMDQ_EN.
module sprite_plotter (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       start,
   input  logic       item,
   input  logic       erase,
   input  logic [2:0] position,
   output logic       ready,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       done
);
   // state  | meaning
   // S_IDLE | waiting for a command
   // S_PLOT | one pixel written per cycle
   // S_DONE | one-cycle completion pulse
   typedef enum logic [1:0] {S_IDLE, S_PLOT, S_DONE} state_t;
   state_t state_q, state_d;

   logic       item_q, item_d;
   logic [7:0] base_x_q, base_x_d;
   logic [5:0] ox_q, ox_d, oy_q, oy_d;
   logic [7:0] x_q, x_d;
   logic [6:0] y_q, y_d;
   logic [2:0] colour_q, colour_d;

   logic       go, l_item, l_erase, l_valid;
   logic [2:0] l_pos, l_col;
   logic [1:0] l_lane;
   logic [7:0] l_x;
   logic [6:0] l_y;
   logic [5:0] last_x, last_y;

`ifdef SPRITE_PLOTTER_CMDQ_EN
   logic       slot_v_q, slot_v_d, slot_item_q, slot_item_d, slot_erase_q, slot_erase_d;
   logic [2:0] slot_pos_q, slot_pos_d;

   // The slot only fills while busy; S_DONE drains it so the next sprite starts without a gap.
   always_comb begin
      slot_v_d     = slot_v_q;
      slot_item_d  = slot_item_q;
      slot_erase_d = slot_erase_q;
      slot_pos_d   = slot_pos_q;
      l_item  = slot_v_q ? slot_item_q  : item;
      l_erase = slot_v_q ? slot_erase_q : erase;
      l_pos   = slot_v_q ? slot_pos_q   : position;
      go      = (state_q == S_IDLE && start) || (state_q == S_DONE && (slot_v_q || start));
      if (state_q == S_DONE) begin
         slot_v_d = 1'b0;
      end else if (state_q == S_PLOT && start && !slot_v_q) begin
         slot_v_d     = 1'b1;
         slot_item_d  = item;
         slot_erase_d = erase;
         slot_pos_d   = position;
      end
   end
`else
   always_comb begin
      l_item  = item;
      l_erase = erase;
      l_pos   = position;
      go      = (state_q == S_IDLE) && start;
   end
`endif

   // Command decode: press steps 4,5 fold back onto lanes 2,1.
   always_comb begin
      l_lane  = l_pos[1:0];
      l_valid = 1'b1;
      if (l_item) begin
         case (l_pos)
            3'd4:       l_lane  = 2'd2;
            3'd5:       l_lane  = 2'd1;
            3'd6, 3'd7: l_valid = 1'b0;
            default:    ;
         endcase
      end else begin
         l_valid = ~l_pos[2];
      end
      l_x   = {1'b0, l_lane, 5'b0} + {3'b0, l_lane, 3'b0} + (l_item ? 8'd0 : 8'd10);
      l_y   = l_item ? 7'd0 : 7'd90;
      l_col = l_erase ? 3'b000 : (l_item ? 3'b111 : 3'b010);
   end

   assign last_x = item_q ? 6'd39 : 6'd19;
   assign last_y = item_q ? 6'd59 : 6'd19;

   always_comb begin
      state_d  = state_q;
      item_d   = item_q;
      base_x_d = base_x_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      if (go) begin
         ox_d = 6'd0;
         oy_d = 6'd0;
         if (l_valid) begin
            state_d  = S_PLOT;
            item_d   = l_item;
            base_x_d = l_x;
            x_d      = l_x;
            y_d      = l_y;
            colour_d = l_col;
         end else begin
            state_d = S_DONE;
         end
      end else begin
         case (state_q)
            S_PLOT: begin
               if (ox_q == last_x) begin
                  if (oy_q == last_y) begin
                     state_d = S_DONE;
                  end else begin
                     ox_d = 6'd0;
                     oy_d = oy_q + 6'd1;
                     x_d  = base_x_q;
                     y_d  = y_q + 7'd1;
                  end
               end else begin
                  ox_d = ox_q + 6'd1;
                  x_d  = x_q + 8'd1;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         item_q   <= 1'b0;
         base_x_q <= 8'd0;
         ox_q     <= 6'd0;
         oy_q     <= 6'd0;
         x_q      <= 8'd0;
         y_q      <= 7'd0;
         colour_q <= 3'd0;
`ifdef SPRITE_PLOTTER_CMDQ_EN
         slot_v_q     <= 1'b0;
         slot_item_q  <= 1'b0;
         slot_erase_q <= 1'b0;
         slot_pos_q   <= 3'd0;
`endif
      end else begin
         state_q  <= state_d;
         item_q   <= item_d;
         base_x_q <= base_x_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
`ifdef SPRITE_PLOTTER_CMDQ_EN
         slot_v_q     <= slot_v_d;
         slot_item_q  <= slot_item_d;
         slot_erase_q <= slot_erase_d;
         slot_pos_q   <= slot_pos_d;
`endif
      end
   end

   always_comb begin
`ifdef SPRITE_PLOTTER_CMDQ_EN
      ready = ~slot_v_q;
`else
      ready = (state_q == S_IDLE);
`endif
      plot   = (state_q == S_PLOT);
      done   = (state_q == S_DONE);
      x      = x_q;
      y      = y_q;
      colour = colour_q;
   end
endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: driver queues expected pixels/done with cycle stamps, monitor checks.
module tb_sprite_plotter;
   logic       clk, rst_n, start, item, erase;
   logic [2:0] position;
   logic       ready, plot, done;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;

   typedef struct {
      bit         is_done;
      int         cyc;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] col;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   sprite_plotter dut (
      .CLOCK_50(clk), .reset_n(rst_n), .start(start), .item(item), .erase(erase),
      .position(position), .ready(ready), .x(x), .y(y), .colour(colour),
      .plot(plot), .done(done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every plot or done cycle must match the head of the scoreboard exactly.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && (plot || done)) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_out: cyc=%0d plot=%b done=%b x=%0d y=%0d", cyc, plot, done, x, y);
         end else begin
            e = q.pop_front();
            if (e.is_done != done || e.is_done == plot || e.cyc != cyc ||
                (!e.is_done && (x != e.x || y != e.y || colour != e.col))) begin
               bad++;
               $display("FAIL out: got cyc=%0d plot=%b done=%b x=%0d y=%0d col=%b expected cyc=%0d done=%b x=%0d y=%0d col=%b",
                        cyc, plot, done, x, y, colour, e.cyc, e.is_done, e.x, e.y, e.col);
            end
         end
      end
   end

   task automatic push_cmd(input int base, input int ox, input int oy, input int w, input int h,
                           input logic [2:0] col);
      exp_t e;
      for (int j = 0; j < h; j++)
         for (int i = 0; i < w; i++) begin
            e.is_done = 1'b0;
            e.cyc     = base + 1 + j * w + i;
            e.x       = 8'(ox + i);
            e.y       = 7'(oy + j);
            e.col     = col;
            q.push_back(e);
         end
      e.is_done = 1'b1;
      e.cyc     = base + 1 + w * h;
      e.x       = 8'd0;
      e.y       = 7'd0;
      e.col     = 3'd0;
      q.push_back(e);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ready) chk("ready_timeout", 0, 1);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 6000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("queue_drained", q.size(), 0);
   endtask

   task automatic pulse_cmd(input logic it, input logic er, input logic [2:0] pos);
      start = 1'b1; item = it; erase = er; position = pos;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic it, input logic er, input logic [2:0] pos,
                       input int ox, input int oy, input int w, input int h, input logic [2:0] col);
      int base;
      wait_ready();
      base = cyc;
      push_cmd(base, ox, oy, w, h, col);
      pulse_cmd(it, er, pos);
`ifdef SPRITE_PLOTTER_CMDQ_EN
      chk("ready_with_empty_slot", ready, 1);
      drain();
`else
      wait_ready();
      chk("ready_latency", cyc - base, 2 + w * h);
`endif
   endtask

   initial begin
      int base;
      rst_n = 1'b0; start = 1'b0; item = 1'b0; erase = 1'b0; position = 3'd0;
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_plot", plot, 0);
      chk("rst_done", done, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_colour", colour, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // garbage lane 2: (90,90)..(109,109)
      send(1'b0, 1'b0, 3'd2, 90, 90, 20, 20, 3'b010);
      // press step 4 -> lane 2, erased
      send(1'b1, 1'b1, 3'd4, 80, 0, 40, 60, 3'b000);
      // invalid garbage lane: done only
      send(1'b0, 1'b0, 3'd5, 0, 0, 0, 0, 3'b000);
      chk("hold_x_after_invalid", x, 119);
      chk("hold_colour_after_invalid", colour, 0);
      // invalid press step
      send(1'b1, 1'b0, 3'd7, 0, 0, 0, 0, 3'b000);
      // press step 0, garbage lane 3 erased
      send(1'b1, 1'b0, 3'd0, 0, 0, 40, 60, 3'b111);
      send(1'b0, 1'b1, 3'd3, 130, 90, 20, 20, 3'b000);

      // reset in the middle of a press sprite
      wait_ready();
      base = cyc;
      push_cmd(base, 0, 0, 40, 60, 3'b111);
      pulse_cmd(1'b1, 1'b0, 3'd0);
      while (cyc < base + 1000) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      #1 rst_n = 1'b0;
      q.delete();
      #1;
      chk("abort_plot", plot, 0);
      chk("abort_done", done, 0);
      chk("abort_ready", ready, 1);
      chk("abort_x", x, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      send(1'b0, 1'b0, 3'd0, 10, 90, 20, 20, 3'b010);

      // start while busy with a press sprite
      wait_ready();
      base = cyc;
      push_cmd(base, 40, 0, 40, 60, 3'b111);
      pulse_cmd(1'b1, 1'b0, 3'd5);
      repeat (4) @(posedge clk);
      #1;
`ifdef SPRITE_PLOTTER_CMDQ_EN
      push_cmd(base + 2401, 10, 90, 20, 20, 3'b010);
      pulse_cmd(1'b0, 1'b0, 3'd0);
      chk("slot_full_ready", ready, 0);
      drain();
`else
      start = 1'b1; item = 1'b0; erase = 1'b0; position = 3'd0;
      while (cyc < base + 2300) begin
         @(posedge clk); #1;
      end
      start = 1'b0;
      wait_ready();
      chk("busy_ignored_latency", cyc - base, 2402);
      drain();
`endif
      repeat (10) @(posedge clk);
      #1;
      chk("final_queue", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
